vga_screen_mux: RTL and testbench

//  Frame-synchronous N-way VGA source selector for the top level (game board, win screen, lose screen, ...).

---
 rtl/vga_screen_mux.sv | 133 +++++++++++++
 tb/tb_vga_screen_mux.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/vga_screen_mux.sv
// vga_screen_mux: frame-synchronous N-way VGA source selector.
// Picks the highest-priority requesting source, switches only on a falling
// vsync edge of the shown source, and holds a new selection for HOLD_FRAMES
// frame boundaries before another switch is allowed. RGB/sync are registered.
// Optional feature macro: VMUX_BLANK_SWITCH_EN (blank RGB for one frame of the
// new source after every switch).
module vga_screen_mux #(
  parameter int NUM_SRC     = 3,
  parameter int COLOR_W     = 4,
  parameter int HOLD_FRAMES = 1,
  localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  localparam int HC_W  = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1
) (
  input  logic                       dclk,
  input  logic                       clr,
  input  logic [NUM_SRC-1:0]         req,
  input  logic [NUM_SRC*3*COLOR_W-1:0] src_rgb,
  input  logic [NUM_SRC-1:0]         src_hsync,
  input  logic [NUM_SRC-1:0]         src_vsync,
  output logic [COLOR_W-1:0]         red,
  output logic [COLOR_W-1:0]         green,
  output logic [COLOR_W-1:0]         blue,
  output logic                       hsync,
  output logic                       vsync,
  output logic [SEL_W-1:0]           sel,
  output logic                       switching
);

  localparam int PIX_W = 3 * COLOR_W;
  localparam logic [HC_W-1:0] HOLD_MAX = HC_W'(HOLD_FRAMES);

  logic [SEL_W-1:0] target;
  logic [PIX_W-1:0] cur_rgb;
  logic             cur_hs;
  logic             cur_vs;
  logic             vs_prev;
  logic             boundary;
  logic             in_show;
  logic             blank;
  logic             do_switch;
  logic [HC_W-1:0]  hold_cnt;

  // Priority encode: highest requesting index wins, no request means source 0
  always_comb begin
    target = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (req[i]) target = SEL_W'(i);
  end

  // Route the currently shown source; unreachable sel codes fall back to source 0
  always_comb begin
    cur_rgb = src_rgb[PIX_W-1:0];
    cur_hs  = src_hsync[0];
    cur_vs  = src_vsync[0];
    for (int i = 1; i < NUM_SRC; i++) begin
      if (sel == SEL_W'(i)) begin
        cur_rgb = src_rgb[i*PIX_W +: PIX_W];
        cur_hs  = src_hsync[i];
        cur_vs  = src_vsync[i];
      end
    end
  end

  // Falling vsync of the shown source marks a frame boundary
  assign boundary  = vs_prev & ~cur_vs;
  assign do_switch = boundary & in_show & (target != sel) & (hold_cnt == HOLD_MAX);

`ifdef VMUX_BLANK_SWITCH_EN
  typedef enum logic {SHOW, BLANK} state_t;
  state_t state, state_nxt;

  // State register
  always_ff @(posedge dclk) begin
    if (!clr) state <= SHOW;
    else      state <= state_nxt;
  end

  // BLANK covers exactly one frame of the newly selected source
  always_comb begin
    state_nxt = state;
    case (state)
      SHOW:    if (do_switch) state_nxt = BLANK;
      BLANK:   if (boundary)  state_nxt = SHOW;
      default: state_nxt = SHOW;
    endcase
  end

  assign in_show = (state == SHOW);
  assign blank   = (state == BLANK);
`else
  assign in_show = 1'b1;
  assign blank   = 1'b0;
`endif

  // Selection, hold counter and boundary tracking
  always_ff @(posedge dclk) begin
    if (!clr) begin
      sel       <= '0;
      hold_cnt  <= HOLD_MAX;
      vs_prev   <= 1'b1;
      switching <= 1'b0;
    end else begin
      switching <= do_switch;
      if (do_switch) begin
        sel      <= target;
        hold_cnt <= '0;
        // Force the new source to show a full high-then-low vsync first
        vs_prev  <= 1'b0;
      end else begin
        vs_prev <= cur_vs;
        if (boundary && hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + HC_W'(1);
      end
    end
  end

  // Registered pin drive, one cycle behind sel
  always_ff @(posedge dclk) begin
    if (!clr) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      red   <= blank ? '0 : cur_rgb[3*COLOR_W-1:2*COLOR_W];
      green <= blank ? '0 : cur_rgb[2*COLOR_W-1:COLOR_W];
      blue  <= blank ? '0 : cur_rgb[COLOR_W-1:0];
      hsync <= cur_hs;
      vsync <= cur_vs;
    end
  end

endmodule

// File: tb/tb_vga_screen_mux.sv
// Directed bench for vga_screen_mux: one instance with HOLD_FRAMES=1 (u1) and
// one with HOLD_FRAMES=2 (u2) share all inputs. All sources share a vsync
// waveform so every falling edge is a boundary for whichever source is shown.
module tb_vga_screen_mux;
  localparam int N = 3;
  localparam int C = 4;
`ifdef VMUX_BLANK_SWITCH_EN
  localparam bit BLK = 1'b1;
`else
  localparam bit BLK = 1'b0;
`endif
  localparam logic [11:0] P0 = 12'h123;
  localparam logic [11:0] P1 = 12'h456;
  localparam logic [11:0] P2 = 12'h789;

  logic dclk = 1'b0;
  logic clr = 1'b0;
  logic [N-1:0] req, src_hsync, src_vsync;
  logic [N*3*C-1:0] src_rgb;
  logic [C-1:0] r1, g1, b1, r2, g2, b2;
  logic hs1, vs1, hs2, vs2, sw1, sw2;
  logic [1:0] sel1, sel2;
  int nvec = 0;
  int nerr = 0;
  logic seen;

  vga_screen_mux #(.NUM_SRC(N), .COLOR_W(C), .HOLD_FRAMES(1)) u1 (
    .dclk(dclk), .clr(clr), .req(req), .src_rgb(src_rgb),
    .src_hsync(src_hsync), .src_vsync(src_vsync),
    .red(r1), .green(g1), .blue(b1), .hsync(hs1), .vsync(vs1),
    .sel(sel1), .switching(sw1));

  vga_screen_mux #(.NUM_SRC(N), .COLOR_W(C), .HOLD_FRAMES(2)) u2 (
    .dclk(dclk), .clr(clr), .req(req), .src_rgb(src_rgb),
    .src_hsync(src_hsync), .src_vsync(src_vsync),
    .red(r2), .green(g2), .blue(b2), .hsync(hs2), .vsync(vs2),
    .sel(sel2), .switching(sw2));

  always #5 dclk = ~dclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge dclk);
    #1;
  endtask

  task automatic vfall();
    src_vsync = '0;
    tick();
  endtask

  task automatic vrise();
    src_vsync = '1;
    tick();
  endtask

  initial begin
    src_rgb   = {P2, P1, P0};
    req       = 3'b111;
    src_hsync = 3'b000;
    src_vsync = 3'b000;
    clr       = 1'b0;
    tick(); tick();
    src_vsync = '1;
    tick();
    chk("rst_sel",  32'(sel1), 32'd0);
    chk("rst_rgb",  32'({r1, g1, b1}), 32'd0);
    chk("rst_hs",   32'(hs1), 32'd1);
    chk("rst_vs",   32'(vs1), 32'd1);
    chk("rst_sw",   32'(sw1), 32'd0);
    chk("rst_sel2", 32'(sel2), 32'd0);

    // Default source shown after release
    clr = 1'b1; src_hsync = 3'b010; req = 3'b001;
    tick(); tick();
    chk("src0_rgb", 32'({r1, g1, b1}), 32'(P0));
    chk("src0_hs",  32'(hs1), 32'd0);
    vfall();
    chk("a_sel", 32'(sel1), 32'd0);
    chk("a_sw",  32'(sw1), 32'd0);
    vrise();

    // Mid-frame request waits for boundary
    req = 3'b100;
    tick(); tick(); tick();
    chk("b_mid_sel", 32'(sel1), 32'd0);
    chk("b_mid_sw",  32'(sw1), 32'd0);
    vfall();
    chk("b_sel",  32'(sel1), 32'd2);
    chk("b_sw",   32'(sw1), 32'd1);
    chk("b_sel2", 32'(sel2), 32'd2);
    chk("b_sw2",  32'(sw2), 32'd1);
    tick();
    chk("b_sw_off", 32'(sw1), 32'd0);
    chk("b_rgb",    32'({r1, g1, b1}), BLK ? 32'd0 : 32'(P2));
    chk("b_vs",     32'(vs1), 32'd0);

    // Hold: u1 needs 1 boundary, u2 needs 2
    req = 3'b001;
    vrise(); vfall();
    chk("c_sel",  32'(sel1), 32'd2);
    chk("c_sw",   32'(sw1), 32'd0);
    chk("c_sel2", 32'(sel2), 32'd2);
    tick();
    chk("c_rgb", 32'({r1, g1, b1}), 32'(P2));
    vrise(); vfall();
    chk("d_sel",  32'(sel1), 32'd0);
    chk("d_sw",   32'(sw1), 32'd1);
    chk("d_sel2", 32'(sel2), 32'd2);
    chk("d_sw2",  32'(sw2), 32'd0);
    vrise(); vfall();
    chk("e_sel2", 32'(sel2), 32'd0);
    chk("e_sw2",  32'(sw2), 32'd1);
    chk("e_sel",  32'(sel1), 32'd0);
    chk("e_sw",   32'(sw1), 32'd0);

    // Priority: 110 picks source 2
    req = 3'b110;
    vrise(); vfall();
    chk("f_sel",  32'(sel1), 32'd2);
    chk("f_sw",   32'(sw1), 32'd1);
    chk("f_sel2", 32'(sel2), 32'd0);

    // No request returns to source 0 at the next allowed boundary
    req = 3'b000;
    vrise(); vfall();
    chk("g_hold_sel", 32'(sel1), 32'd2);
    vrise(); vfall();
    chk("g_sel", 32'(sel1), 32'd0);
    chk("g_sw",  32'(sw1), 32'd1);

    // Glitch request between boundaries is ignored
    vrise(); vfall(); vrise();
    seen = 1'b0;
    req = 3'b100;
    repeat (5) begin tick(); seen = seen | sw1 | sw2; end
    req = 3'b000;
    repeat (5) begin tick(); seen = seen | sw1 | sw2; end
    vfall();
    seen = seen | sw1 | sw2;
    chk("h_glitch_sw", 32'(seen), 32'd0);
    chk("h_sel",       32'(sel1), 32'd0);
    vrise();

    // Request changes in the boundary cycle itself
    req = 3'b010; src_vsync = '0;
    tick();
    chk("i_sel",  32'(sel1), 32'd1);
    chk("i_sw",   32'(sw1), 32'd1);
    chk("i_sel2", 32'(sel2), 32'd1);
    chk("i_sw2",  32'(sw2), 32'd1);

    // One frame of the new source (blanked when the feature is on)
    tick();
    chk("i_rgb0", 32'({r1, g1, b1}), BLK ? 32'd0 : 32'(P1));
    chk("i_hs0",  32'(hs1), 32'd1);
    chk("i_vs0",  32'(vs1), 32'd0);
    vrise();
    chk("i_vs1",  32'(vs1), 32'd1);
    tick(); tick(); tick();
    chk("i_rgb1", 32'({r1, g1, b1}), BLK ? 32'd0 : 32'(P1));
    vfall();
    chk("i_rgb2", 32'({r1, g1, b1}), BLK ? 32'd0 : 32'(P1));
    chk("i_vs2",  32'(vs1), 32'd0);
    chk("i_sw2b", 32'(sw1), 32'd0);
    tick();
    chk("i_rgb3", 32'({r1, g1, b1}), 32'(P1));
    chk("i_hs3",  32'(hs1), 32'd1);

    // Stuck-high vsync: no boundary, no switch
    src_vsync = '1; req = 3'b100;
    repeat (20) tick();
    chk("stuck_sel",  32'(sel1), 32'd1);
    chk("stuck_sel2", 32'(sel2), 32'd1);

    // Reset mid-frame
    clr = 1'b0;
    tick();
    chk("mrst_sel", 32'(sel1), 32'd0);
    chk("mrst_rgb", 32'({r1, g1, b1}), 32'd0);
    chk("mrst_hs",  32'(hs1), 32'd1);
    chk("mrst_sw",  32'(sw1), 32'd0);
    clr = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
